// File: rtl/lstm_pkg.sv
// lstm_pkg: shared constants, data type and sequencer state encoding for the
// Q6.11 LSTM datapath and its sequencing controller.
//   WIDTH            - data word width (Q6.11, signed)
//   FRAC             - number of fractional bits
//   q6_11_t          - signed Q6.11 data word
//   lstm_seq_state_t - lstm_seq_ctrl FSM states
package lstm_pkg;

  localparam int WIDTH = 18;
  localparam int FRAC  = 11;

  typedef logic signed [WIDTH-1:0] q6_11_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    COMPUTE,
    EMIT,
    DONE
  } lstm_seq_state_t;

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// lstm_seq_ctrl_if: sample-in and result-out streams of the LSTM sequencer.
//   x_valid/x_ready/x_data           - input sample stream (upstream buffer -> ctrl)
//   out_valid/out_ready/out_h/out_c  - result stream (ctrl -> readout stage)
//   out_last                         - marks the final timestep's result
// Modports:
//   master - controller side (accepts samples, drives results)
//   slave  - environment side (supplies samples, consumes results)
interface lstm_seq_ctrl_if #(
  parameter int WIDTH = 18
);

  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] x_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_h;
  logic [WIDTH-1:0] out_c;
  logic             out_last;

  modport master (
    input  x_valid, x_data, out_ready,
    output x_ready, out_valid, out_h, out_c, out_last
  );

  modport slave (
    output x_valid, x_data, out_ready,
    input  x_ready, out_valid, out_h, out_c, out_last
  );

endinterface

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: runs a Q6.11 LSTM cell over seq_len timesteps. Each accepted
// sample is presented to the cell together with the held h/c state; after the
// cell latency the new h/c is captured as state and offered downstream.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, seq_len      - begin a run of seq_len steps (start sampled in IDLE)
//   init_sel            - 1: load h_init/c_init at start, 0: keep prior state
//   h_init, c_init      - initial hidden / cell state
//   busy, done          - not-IDLE flag, one-cycle end-of-sequence pulse
//   io (master)         - sample-in and result-out streams
//   cell_x/h_prev/c_prev- registered operands to the cell
//   cell_h, cell_c      - cell results
//   step_idx            - current 0-based step
//
// Build option: LSTM_SEQ_LAST_ONLY_EN - when defined, only the final step's
// result is emitted; intermediate steps go straight back to WAIT_X.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// WAIT_X  | x_ready high, waiting for an input sample
// COMPUTE | cell operands held, counting down cell latency
// EMIT    | result offered on out stream
// DONE    | one-cycle done pulse
module lstm_seq_ctrl #(
  parameter int WIDTH    = 18,
  parameter int CNT_W    = 10,
  parameter int CELL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] seq_len,
  input  logic             init_sel,
  input  logic [WIDTH-1:0] h_init,
  input  logic [WIDTH-1:0] c_init,
  output logic             busy,
  output logic             done,
  lstm_seq_ctrl_if.master  io,
  output logic [WIDTH-1:0] cell_x,
  output logic [WIDTH-1:0] cell_h_prev,
  output logic [WIDTH-1:0] cell_c_prev,
  input  logic [WIDTH-1:0] cell_h,
  input  logic [WIDTH-1:0] cell_c,
  output logic [CNT_W-1:0] step_idx
);

  import lstm_pkg::*;

  localparam int LAT_W = $clog2(CELL_LAT + 1);

  lstm_seq_state_t  state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] step_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [WIDTH-1:0] h_q, c_q;
  logic [WIDTH-1:0] out_h_q, out_c_q;
  logic             is_last;
  logic             x_fire;
  logic             lat_done;
  logic             step_inc;

  // len_q is nonzero whenever is_last is consulted (zero-length runs go straight to DONE)
  assign is_last  = (step_q == len_q - 1'b1);
  assign x_fire   = (state == WAIT_X) && io.x_valid;
  assign lat_done = (state == COMPUTE) && (lat_cnt == '0);

`ifdef LSTM_SEQ_LAST_ONLY_EN
  assign step_inc = lat_done && !is_last;
`else
  assign step_inc = (state == EMIT) && io.out_ready && !is_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    done         = (state == DONE);
    io.x_ready   = (state == WAIT_X);
    io.out_valid = (state == EMIT);
    io.out_last  = (state == EMIT) && is_last;
    case (state)
      IDLE:    if (start) state_nxt = (seq_len == '0) ? DONE : WAIT_X;
      WAIT_X:  if (io.x_valid) state_nxt = COMPUTE;
      COMPUTE: begin
        if (lat_cnt == '0) begin
`ifdef LSTM_SEQ_LAST_ONLY_EN
          state_nxt = is_last ? EMIT : WAIT_X;
`else
          state_nxt = EMIT;
`endif
        end
      end
      EMIT:    if (io.out_ready) state_nxt = is_last ? DONE : WAIT_X;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      step_q      <= '0;
      lat_cnt     <= '0;
      h_q         <= '0;
      c_q         <= '0;
      cell_x      <= '0;
      cell_h_prev <= '0;
      cell_c_prev <= '0;
      out_h_q     <= '0;
      out_c_q     <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        len_q  <= seq_len;
        step_q <= '0;
        if (init_sel) begin
          h_q <= h_init;
          c_q <= c_init;
        end
      end
      if (x_fire) begin
        cell_x      <= io.x_data;
        cell_h_prev <= h_q;
        cell_c_prev <= c_q;
        lat_cnt     <= LAT_W'(CELL_LAT);
      end else if ((state == COMPUTE) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (lat_done) begin
        h_q     <= cell_h;
        c_q     <= cell_c;
        out_h_q <= cell_h;
        out_c_q <= cell_c;
      end
      if (step_inc) step_q <= step_q + 1'b1;
    end
  end

  assign io.out_h = out_h_q;
  assign io.out_c = out_c_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: directed bench for lstm_seq_ctrl with a latency-1 stub
// cell (h_t = x_t + h_prev, c_t = c_prev + 1). A step-level model predicts
// every emitted result; a per-cycle compare process checks the out stream.
module tb_lstm_seq_ctrl;

  localparam int WIDTH    = 18;
  localparam int CNT_W    = 10;
  localparam int CELL_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] seq_len = '0;
  logic             init_sel = 1'b0;
  logic [WIDTH-1:0] h_init = '0;
  logic [WIDTH-1:0] c_init = '0;
  logic             busy, done;
  logic [WIDTH-1:0] cell_x, cell_h_prev, cell_c_prev;
  logic [WIDTH-1:0] cell_h, cell_c;
  logic [CNT_W-1:0] step_idx;

  always #5 clk = ~clk;

  lstm_seq_ctrl_if #(.WIDTH(WIDTH)) io ();

  lstm_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CELL_LAT(CELL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .init_sel(init_sel),
    .h_init(h_init), .c_init(c_init), .busy(busy), .done(done), .io(io),
    .cell_x(cell_x), .cell_h_prev(cell_h_prev), .cell_c_prev(cell_c_prev),
    .cell_h(cell_h), .cell_c(cell_c), .step_idx(step_idx)
  );

  // stub cell, latency 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_h <= '0;
      cell_c <= '0;
    end else begin
      cell_h <= cell_x + cell_h_prev;
      cell_c <= cell_c_prev + 18'd1;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] c;
    logic             last;
    logic [CNT_W-1:0] step;
  } exp_t;

  exp_t             expq[$];
  logic [WIDTH-1:0] h_m = '0, c_m = '0;
  int               len_m = 0, k_m = 0;
  int               tests = 0, fails = 0;
  int               cyc = 0, hs_edge = -100, done_cnt = 0, n_out = 0;
  logic [WIDTH-1:0] last_out_h = '0, last_out_c = '0;
  logic             prev_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && io.out_valid && io.out_ready && expq.size() > 0) begin
      last_out_h <= io.out_h;
      last_out_c <= io.out_c;
      n_out      <= n_out + 1;
      void'(expq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (io.out_valid) begin
        if (expq.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          chk("out_h", io.out_h, expq[0].h);
          chk("out_c", io.out_c, expq[0].c);
          chk("out_last", io.out_last, expq[0].last);
          chk("step_idx", step_idx, expq[0].step);
          if (!prev_ov) chk("out_latency", cyc - hs_edge, CELL_LAT + 1);
        end
        chk("x_ready_in_emit", io.x_ready, 0);
      end else begin
        chk("out_last_idle", io.out_last, 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 1);
      end
      prev_ov <= io.out_valid;
    end else begin
      prev_ov <= 1'b0;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_x_ready"}, io.x_ready, 0);
    chk({tag, "_out_valid"}, io.out_valid, 0);
    chk({tag, "_out_last"}, io.out_last, 0);
    chk({tag, "_out_h"}, io.out_h, 0);
    chk({tag, "_out_c"}, io.out_c, 0);
    chk({tag, "_cell_x"}, cell_x, 0);
    chk({tag, "_cell_h_prev"}, cell_h_prev, 0);
    chk({tag, "_cell_c_prev"}, cell_c_prev, 0);
    chk({tag, "_step_idx"}, step_idx, 0);
  endtask

  task automatic start_seq(input logic isel, input logic [WIDTH-1:0] hi,
                           input logic [WIDTH-1:0] ci, input int len);
    @(negedge clk);
    start    = 1'b1;
    init_sel = isel;
    h_init   = hi;
    c_init   = ci;
    seq_len  = len[CNT_W-1:0];
    if (isel) begin
      h_m = hi;
      c_m = ci;
    end
    len_m = len;
    k_m   = 0;
    @(negedge clk);
    start   = 1'b0;
    seq_len = '1;     // later changes must not matter
    h_init  = 18'h2aaaa;
    c_init  = 18'h15555;
  endtask

  task automatic send_x(input logic [WIDTH-1:0] x);
    int   n = 0;
    exp_t e;
    while (io.x_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (io.x_ready !== 1'b1) begin
      chk("x_ready_timeout", io.x_ready, 1);
      return;
    end
    io.x_valid = 1'b1;
    io.x_data  = x;
    hs_edge    = cyc + 1;
    @(negedge clk);
    io.x_valid = 1'b0;
    io.x_data  = WIDTH'($urandom);
    chk("cell_x", cell_x, x);
    chk("cell_h_prev", cell_h_prev, h_m);
    chk("cell_c_prev", cell_c_prev, c_m);
    h_m    = x + h_m;
    c_m    = c_m + 18'd1;
    e.h    = h_m;
    e.c    = c_m;
    e.last = (k_m == len_m - 1);
    e.step = k_m[CNT_W-1:0];
`ifdef LSTM_SEQ_LAST_ONLY_EN
    if (e.last) expq.push_back(e);
`else
    expq.push_back(e);
`endif
    k_m++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("queue_drained", expq.size(), 0);
  endtask

  task automatic stall5();
    int               n = 0;
    logic [WIDTH-1:0] hold;
    while (io.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_out_valid_seen", io.out_valid, 1);
    hold = io.out_h;
    // stray start while busy must be ignored
    start = 1'b1; seq_len = 10'd9; init_sel = 1'b1; h_init = 18'h11111; c_init = 18'h00777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t3_hold_valid", io.out_valid, 1);
      chk("t3_hold_h", io.out_h, hold);
      chk("t3_hold_x_ready", io.x_ready, 0);
    end
    io.out_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    io.x_valid   = 1'b0;
    io.x_data    = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // 1: basic run 1.0, 2.0, 3.0
    o0 = n_out;
    start_seq(1'b1, 18'h0, 18'h0, 3);
    send_x(18'h00800);
    send_x(18'h01000);
    send_x(18'h01800);
    wait_done();
    chk("t1_model_h", h_m, 18'h03000);
    chk("t1_model_c", c_m, 18'd3);
    chk("t1_last_out_h", last_out_h, 18'h03000);
    chk("t1_last_out_c", last_out_c, 18'd3);
`ifdef LSTM_SEQ_LAST_ONLY_EN
    chk("t1_results", n_out - o0, 1);
`else
    chk("t1_results", n_out - o0, 3);
`endif

    // 4: state retention with init_sel=0
    start_seq(1'b0, 18'h12345, 18'h00abc, 1);
    send_x(18'h00800);
    wait_done();
    chk("t4_last_out_h", last_out_h, 18'h03800);
    chk("t4_last_out_c", last_out_c, 18'd4);

    // 2: empty sequence
    start_seq(1'b0, 18'h0, 18'h0, 0);
    chk("t2_done", done, 1);
    chk("t2_x_ready", io.x_ready, 0);
    chk("t2_out_valid", io.out_valid, 0);
    @(negedge clk);
    chk("t2_done_clear", done, 0);
    chk("t2_idle", busy, 0);

    // 3: back-pressure, h_init=-1.0 so step 0 wraps to 0
    io.out_ready = 1'b0;
    start_seq(1'b1, 18'h3f800, 18'd10, 2);
    send_x(18'h00800);
`ifdef LSTM_SEQ_LAST_ONLY_EN
    send_x(18'h01000);
    stall5();
`else
    stall5();
    send_x(18'h01000);
`endif
    wait_done();
    chk("t3_last_out_h", last_out_h, 18'h01000);
    chk("t3_last_out_c", last_out_c, 18'd12);

    // 5: reset during COMPUTE of step 1
    start_seq(1'b1, 18'h0, 18'h0, 3);
    send_x(18'h00800);
    send_x(18'h01000);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    chk_zero("t5_rst");
    expq.delete();
    h_m = '0;
    c_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle", busy, 0);
    start_seq(1'b0, 18'h2aaaa, 18'h15555, 3);
    send_x(18'h00800);
    send_x(18'h01000);
    send_x(18'h01800);
    wait_done();
    chk("t5_last_out_h", last_out_h, 18'h03000);
    chk("t5_last_out_c", last_out_c, 18'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
